// File: rtl/fetch.sv
// uRISC instruction fetch: owns the fetch PC, issues one imem request at a time
// and feeds the IF/ID register, applying decode/execute redirects and halt.
module fetch #(
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter logic [15:0] EXC_VECTOR = 16'h0002,
  parameter logic [15:0] NOP_INST   = 16'h0800
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid_p1,
  output logic [15:0] imem_req_addr_p1,
  input  logic        imem_req_ready_p1,
  input  logic        imem_rsp_valid_p1,
  input  logic [15:0] imem_rsp_data_p1,
  input  logic        stall_idif_p1,
  input  logic        halt_idif_p1,
  input  logic        illegal_op_idif_p1,
  input  logic        return_execution_idif_p1,
  input  logic        jmp_displacement_idif_p1,
  input  logic [15:0] jmp_displacement_value_idif_p1,
  input  logic        redirect_ixif_p1,
  input  logic [15:0] redirect_target_ixif_p1,
  output logic [15:0] inst_ifid_p1,
  output logic [15:0] pc_p1,
  output logic        inst_valid_ifid_p1,
  output logic [15:0] epc_p1
);

  typedef enum logic [1:0] {S_FETCH, S_WAIT, S_HOLD, S_HALTED} state_t;

  state_t      r_state,     w_state;
  logic [15:0] r_fetch_pc,  w_fetch_pc;
  logic [15:0] r_req_addr,  w_req_addr;
  logic        r_drop,      w_drop;
  logic [15:0] r_hold_inst, w_hold_inst;
  logic [15:0] r_hold_pc,   w_hold_pc;
  logic [15:0] r_inst,      w_inst;
  logic [15:0] r_pc,        w_pc;
  logic        r_valid,     w_valid;
  logic [15:0] r_epc,       w_epc;

  logic        w_dq, w_exr, w_ill, w_rti, w_jmp, w_redir, w_halt;
  logic        w_accept, w_outstanding;
  logic [15:0] w_target;

  assign imem_req_valid_p1  = (r_state == S_FETCH) && !rst;
  assign imem_req_addr_p1   = r_fetch_pc;
  assign inst_ifid_p1       = r_inst;
  assign pc_p1              = r_pc;
  assign inst_valid_ifid_p1 = r_valid;
  assign epc_p1             = r_epc;

  // Decode events only count for a real instruction that decode is consuming.
  assign w_dq    = r_valid && !stall_idif_p1;
  assign w_exr   = redirect_ixif_p1 && (r_state != S_HALTED);
  assign w_ill   = w_dq && illegal_op_idif_p1;
  assign w_rti   = w_dq && return_execution_idif_p1;
  assign w_jmp   = w_dq && jmp_displacement_idif_p1;
  assign w_redir = w_exr || w_ill || w_rti || w_jmp;
  assign w_halt  = w_dq && halt_idif_p1 && !w_redir;

  assign w_target = w_exr ? redirect_target_ixif_p1 :
                    w_ill ? EXC_VECTOR :
                    w_rti ? r_epc :
                    r_pc + jmp_displacement_value_idif_p1;

  // A response landing this very cycle is consumed here, so it is not outstanding.
  assign w_accept      = imem_req_valid_p1 && imem_req_ready_p1;
  assign w_outstanding = w_accept || ((r_state == S_WAIT) && !imem_rsp_valid_p1);

  always_comb begin
    w_state     = r_state;
    w_fetch_pc  = r_fetch_pc;
    w_req_addr  = r_req_addr;
    w_drop      = r_drop;
    w_hold_inst = r_hold_inst;
    w_hold_pc   = r_hold_pc;
    w_inst      = r_inst;
    w_pc        = r_pc;
    w_valid     = r_valid;
    w_epc       = (w_ill && !w_exr) ? r_pc : r_epc;
    if (!stall_idif_p1) begin
      w_inst  = NOP_INST;
      w_valid = 1'b0;
    end
    case (r_state)
      S_FETCH: if (w_accept) begin
        w_req_addr = r_fetch_pc;
        w_fetch_pc = r_fetch_pc + 16'd2;
        w_state    = S_WAIT;
      end
      S_WAIT: if (imem_rsp_valid_p1) begin
        if (r_drop) begin
          w_drop  = 1'b0;
          w_state = S_FETCH;
        end else if (!stall_idif_p1) begin
          w_inst  = imem_rsp_data_p1;
          w_pc    = r_req_addr + 16'd2;
          w_valid = 1'b1;
          w_state = S_FETCH;
        end else begin
          w_hold_inst = imem_rsp_data_p1;
          w_hold_pc   = r_req_addr + 16'd2;
          w_state     = S_HOLD;
        end
      end
      S_HOLD: if (!stall_idif_p1) begin
        w_inst  = r_hold_inst;
        w_pc    = r_hold_pc;
        w_valid = 1'b1;
        w_state = S_FETCH;
      end
      default: begin
        w_inst  = NOP_INST;
        w_valid = 1'b0;
        if (imem_rsp_valid_p1) w_drop = 1'b0;
      end
    endcase
    if (w_redir || w_halt) begin
      w_inst  = NOP_INST;
      w_valid = 1'b0;
      w_drop  = w_outstanding;
      if (w_redir) begin
        w_fetch_pc = w_target;
        w_state    = w_outstanding ? S_WAIT : S_FETCH;
      end else begin
        w_state = S_HALTED;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_FETCH;
      r_fetch_pc  <= RESET_PC;
      r_req_addr  <= 16'h0000;
      r_drop      <= 1'b0;
      r_hold_inst <= NOP_INST;
      r_hold_pc   <= 16'h0000;
      r_inst      <= NOP_INST;
      r_pc        <= 16'h0000;
      r_valid     <= 1'b0;
      r_epc       <= 16'h0000;
    end else begin
      r_state     <= w_state;
      r_fetch_pc  <= w_fetch_pc;
      r_req_addr  <= w_req_addr;
      r_drop      <= w_drop;
      r_hold_inst <= w_hold_inst;
      r_hold_pc   <= w_hold_pc;
      r_inst      <= w_inst;
      r_pc        <= w_pc;
      r_valid     <= w_valid;
      r_epc       <= w_epc;
    end
  end

  // Memory answers only requests we issued, so unexpected data means a protocol bug.
  always_ff @(posedge clk) begin
    if (!rst && imem_rsp_valid_p1 && !r_drop)
      assert (r_state == S_WAIT);
  end

endmodule

// File: tb/tb_fetch.sv
// Directed bench for fetch: cycle table for the basic flow, then hand sequences
// for traps, RTI, halt, reset recovery and PC wrap.
module tb_fetch;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, rsp_valid;
  logic [15:0] req_addr, rsp_data;
  logic        stall, halt, illegal, rti, jmp, exr;
  logic [15:0] disp, exr_tgt;
  logic [15:0] inst, pc, epc;
  logic        ivalid;
  int          checks = 0, errors = 0;

  always #5 clk = ~clk;

  fetch dut (
    .clk(clk), .rst(rst),
    .imem_req_valid_p1(req_valid), .imem_req_addr_p1(req_addr),
    .imem_req_ready_p1(req_ready), .imem_rsp_valid_p1(rsp_valid),
    .imem_rsp_data_p1(rsp_data), .stall_idif_p1(stall),
    .halt_idif_p1(halt), .illegal_op_idif_p1(illegal),
    .return_execution_idif_p1(rti), .jmp_displacement_idif_p1(jmp),
    .jmp_displacement_value_idif_p1(disp), .redirect_ixif_p1(exr),
    .redirect_target_ixif_p1(exr_tgt), .inst_ifid_p1(inst), .pc_p1(pc),
    .inst_valid_ifid_p1(ivalid), .epc_p1(epc)
  );

  function automatic logic [15:0] memf(input logic [15:0] a);
    case (a)
      16'h0000: return 16'h481F;
      16'h0002: return 16'hA81F;
      default:  return a ^ 16'h3C00;
    endcase
  endfunction

  // One-cycle-latency in-order memory sharing rst.
  always @(posedge clk) begin
    if (rst) rsp_valid <= 1'b0;
    else begin
      rsp_valid <= req_valid && req_ready;
      rsp_data  <= memf(req_addr);
    end
  end

  typedef struct {
    logic        stall, jmp;
    logic [15:0] disp;
    logic        rv;
    logic [15:0] addr, inst, pc;
    logic        vld;
  } vec_t;

  vec_t tbl[13];

  function automatic vec_t mk(input logic s, j, input logic [15:0] d, input logic rv,
                              input logic [15:0] a, i, p, input logic v);
    vec_t t;
    t.stall = s; t.jmp = j; t.disp = d; t.rv = rv;
    t.addr = a; t.inst = i; t.pc = p; t.vld = v;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_req(input string nm, input logic [15:0] exp);
    for (int i = 0; i < 12; i++) begin
      if (req_valid) break;
      tick();
    end
    chk(nm, {req_valid, req_addr}, {1'b1, exp});
  endtask

  task automatic wait_valid(input string nm, input logic [15:0] exp_pc, input logic [15:0] exp_inst);
    for (int i = 0; i < 12; i++) begin
      if (ivalid) break;
      tick();
    end
    chk(nm, {ivalid, pc, inst}, {1'b1, exp_pc, exp_inst});
  endtask

  task automatic goto(input logic [15:0] tgt);
    exr = 1'b1; exr_tgt = tgt;
    tick();
    exr = 1'b0;
  endtask

  initial begin
    tbl[0]  = mk(0, 0, 16'h0000, 1, 16'h0000, 16'h0800, 16'h0000, 0);
    tbl[1]  = mk(0, 0, 16'h0000, 0, 16'h0000, 16'h0800, 16'h0000, 0);
    tbl[2]  = mk(0, 0, 16'h0000, 1, 16'h0002, 16'h481F, 16'h0002, 1);
    tbl[3]  = mk(0, 0, 16'h0000, 0, 16'h0000, 16'h0800, 16'h0002, 0);
    tbl[4]  = mk(1, 0, 16'h0000, 1, 16'h0004, 16'hA81F, 16'h0004, 1);
    tbl[5]  = mk(1, 0, 16'h0000, 0, 16'h0000, 16'hA81F, 16'h0004, 1);
    tbl[6]  = mk(1, 0, 16'h0000, 0, 16'h0000, 16'hA81F, 16'h0004, 1);
    tbl[7]  = mk(0, 0, 16'h0000, 0, 16'h0000, 16'hA81F, 16'h0004, 1);
    tbl[8]  = mk(0, 1, 16'hFFFC, 1, 16'h0006, 16'h3C04, 16'h0006, 1);
    tbl[9]  = mk(0, 0, 16'h0000, 0, 16'h0000, 16'h0800, 16'h0006, 0);
    tbl[10] = mk(0, 0, 16'h0000, 1, 16'h0002, 16'h0800, 16'h0006, 0);
    tbl[11] = mk(0, 0, 16'h0000, 0, 16'h0000, 16'h0800, 16'h0006, 0);
    tbl[12] = mk(0, 0, 16'h0000, 1, 16'h0004, 16'hA81F, 16'h0004, 1);

    rst = 1'b1; req_ready = 1'b1; stall = 1'b0; halt = 1'b0; illegal = 1'b0;
    rti = 1'b0; jmp = 1'b0; exr = 1'b0; disp = 16'h0000; exr_tgt = 16'h0000;
    tick(); tick();
    chk("reset", {req_valid, inst, pc, ivalid, epc}, {1'b0, 16'h0800, 16'h0000, 1'b0, 16'h0000});
    rst = 1'b0;

    for (int k = 0; k < 13; k++) begin
      stall = tbl[k].stall; jmp = tbl[k].jmp; disp = tbl[k].disp;
      #1;
      chk($sformatf("vec%0d", k),
          {req_valid, req_valid ? req_addr : 16'h0000, inst, pc, ivalid},
          {tbl[k].rv, tbl[k].addr, tbl[k].inst, tbl[k].pc, tbl[k].vld});
      tick();
    end
    stall = 1'b0; jmp = 1'b0; disp = 16'h0000;

    // Illegal op alongside an execute redirect: execute wins, EPC untouched.
    goto(16'h000E);
    wait_valid("reach_0010", 16'h0010, 16'h3C0E);
    illegal = 1'b1; exr = 1'b1; exr_tgt = 16'h0040;
    tick();
    illegal = 1'b0; exr = 1'b0;
    chk("flush_exr", {inst, ivalid}, {16'h0800, 1'b0});
    wait_req("exr_wins", 16'h0040);
    chk("epc_kept", epc, 16'h0000);

    goto(16'h000E);
    wait_valid("reach_0010b", 16'h0010, 16'h3C0E);
    illegal = 1'b1;
    tick();
    illegal = 1'b0;
    chk("epc_trap", {epc, inst, ivalid}, {16'h0010, 16'h0800, 1'b0});
    wait_req("trap_vec", 16'h0002);
    wait_valid("after_trap", 16'h0004, 16'hA81F);
    rti = 1'b1;
    tick();
    rti = 1'b0;
    wait_req("rti", 16'h0010);

    // Halt: no requests until reset.
    wait_valid("pre_halt", 16'h0012, 16'h3C10);
    halt = 1'b1;
    tick();
    halt = 1'b0;
    for (int i = 0; i < 20; i++) begin
      chk($sformatf("halted%0d", i), {req_valid, inst, ivalid}, {1'b0, 16'h0800, 1'b0});
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("post_reset", {req_valid, req_addr}, {1'b1, 16'h0000});

    // Wrap at FFFE, with memory back-pressure holding the request first.
    req_ready = 1'b0;
    goto(16'hFFFE);
    wait_req("req_fffe", 16'hFFFE);
    tick(); tick();
    chk("ready_hold", {req_valid, req_addr}, {1'b1, 16'hFFFE});
    req_ready = 1'b1;
    wait_valid("wrap_pc", 16'h0000, 16'hC3FE);
    wait_req("wrap_req", 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch.md
Name: fetch

Overview:
- Instruction fetch stage of the uRISC pipeline; the producer end of the IF/ID interface that decode consumes.
- Owns the fetch PC and issues one 16-bit instruction request at a time to instruction memory.
- Presents the instruction, its PC+2 and a valid flag to decode.
- Applies redirects from decode (jump displacement, illegal-op trap, return from exception, halt) and from execute (branch/jump-register), and holds the exception PC.

Parameters:
- RESET_PC, 16'h0000, fetch PC after reset.
- EXC_VECTOR, 16'h0002, target on illegal opcode.
- NOP_INST, 16'h0800, bubble encoding driven on inst_ifid_p1 when invalid.

Ports:
- clk  in  1  single clock; all state on rising edge
- rst  in  1  synchronous, active-high reset
- imem_req_valid_p1  out  1  fetch request
- imem_req_addr_p1  out  16  request address
- imem_req_ready_p1  in  1  memory accepts request
- imem_rsp_valid_p1  in  1  response data valid (latency ≥1 cycle, in order)
- imem_rsp_data_p1  in  16  instruction word
- stall_idif_p1  in  1  decode cannot accept new IF/ID contents
- halt_idif_p1  in  1  IF/ID instruction is HALT
- illegal_op_idif_p1  in  1  IF/ID instruction is illegal
- return_execution_idif_p1  in  1  IF/ID instruction is RTI
- jmp_displacement_idif_p1  in  1  IF/ID instruction is PC-relative jump
- jmp_displacement_value_idif_p1  in  16  signed displacement
- redirect_ixif_p1  in  1  execute-resolved taken branch/JR
- redirect_target_ixif_p1  in  16  execute target
- inst_ifid_p1  out  16  instruction to decode
- pc_p1  out  16  PC+2 of inst_ifid_p1
- inst_valid_ifid_p1  out  1  IF/ID holds a real instruction
- epc_p1  out  16  exception PC

Behaviour:
- Reset (rst=1 at an edge):
  - fetch_pc=RESET_PC, state=FETCH.
  - inst_ifid_p1=NOP_INST, pc_p1=0, inst_valid_ifid_p1=0, epc_p1=0.
  - Drop flag cleared, hold buffer empty; imem_req_valid_p1=0 in the reset cycle.
  - Reset mid-request abandons it; memory shares rst.
- States: FETCH, WAIT, HOLD, HALTED.
  - FETCH: req_valid=1, addr=fetch_pc. When ready=1: fetch_pc += 2 (16-bit wrap, FFFE→0000), go to WAIT.
  - WAIT: req_valid=0. On rsp_valid:
    - drop=1: clear drop, go to FETCH.
    - else stall=0: load IF/ID (inst=data, pc_p1=request addr+2, valid=1), go to FETCH.
    - else stall=1: capture into hold buffer, go to HOLD.
  - HOLD: req_valid=0. When stall=0: load IF/ID from buffer, go to FETCH.
  - HALTED: req_valid=0, IF/ID=NOP/invalid; exits only on rst.
- IF/ID update: if stall=0 and no new instruction, IF/ID becomes NOP_INST with valid=0. If stall=1, IF/ID holds unless flushed.
- Decode-stage events are qualified by inst_valid_ifid_p1=1 and stall_idif_p1=0.
- Redirect priority (highest first): execute redirect, illegal, RTI, jmp displacement, halt. Targets:
  - execute: redirect_target_ixif_p1
  - illegal: EXC_VECTOR; epc_p1 <= pc_p1 in the same edge
  - RTI: current epc_p1
  - jmp: pc_p1 + displacement, mod 2^16
- Any redirect, same edge:
  - fetch_pc <= target; IF/ID flushed to NOP/valid=0 regardless of stall; hold buffer discarded.
  - If a request is outstanding (WAIT, or FETCH with ready=1 this cycle), set drop and go to WAIT; otherwise go to FETCH. Next request uses the new target.
- Halt (qualified, no execute redirect): go to HALTED, flush IF/ID, set drop if a request is outstanding. An execute redirect in the same cycle wins, and halt is ignored.
- Response arriving in FETCH/HOLD/HALTED with drop=0 is a protocol error (assertion).
- Throughput: one instruction per 2 cycles with 1-cycle memory; no prefetch beyond one request.

Test Plan:
- Reset, memory latency 1, mem[0]=16'h481F, mem[2]=16'hA81F → requests at 0000, 0002; IF/ID shows 481F/pc_p1=0002, then A81F/0004, valid=1.
- stall_idif_p1=1 while response for 0004 returns → HOLD; IF/ID keeps A81F; on release it shows the 0004 word with pc_p1=0006; no extra request issued during HOLD.
- jmp_displacement_idif_p1=1, value 16'hFFFC, pc_p1=0006, response outstanding → in-flight response dropped; next request addr=0002; IF/ID=0800/valid=0 for the flush cycle.
- Illegal op at pc_p1=0010 with redirect_ixif_p1=1 (target 0040) in the same cycle → next request at 0040; epc_p1 unchanged. Repeat without the execute redirect → epc_p1=0010, next request at 0002. Then RTI → next request at 0010.
- halt_idif_p1=1 → no further imem_req_valid_p1 for 20 cycles, IF/ID=0800. Assert rst one cycle → request at 0000 next.
- fetch_pc=FFFE → request FFFE, then 0000; pc_p1=0000 for the FFFE instruction.
